// File: rtl/calc2_pkg.sv
// Shared command/response encodings and the response record for the calc2 responder.
package calc2_pkg;

  localparam int CALC2_DATA_W = 32;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  // An all-zero record is an empty delay-line slot.
  typedef struct packed {
    logic [1:0]              resp;
    logic [CALC2_DATA_W-1:0] data;
    logic [1:0]              tag;
  } rsp_t;

endpackage

// File: rtl/calc2_alu.sv
// Combinational calc2 datapath: add/sub with range errors, logical shifts, invalid-cmd errors.
module calc2_alu
  import calc2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        i_cmd,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  output logic [1:0]        o_resp,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W:0] w_sum;
  assign w_sum = {1'b0, i_op1} + {1'b0, i_op2};

  always_comb begin
    o_resp = RESP_ERR;
    o_data = '0;
    case (i_cmd)
      CMD_ADD: if (!w_sum[DATA_W]) begin
        o_resp = RESP_OK;
        o_data = w_sum[DATA_W-1:0];
      end
      CMD_SUB: if (i_op2 <= i_op1) begin
        o_resp = RESP_OK;
        o_data = i_op1 - i_op2;
      end
      CMD_SHL: begin
        o_resp = RESP_OK;
        o_data = i_op1 << i_op2[4:0];
      end
      CMD_SHR: begin
        o_resp = RESP_OK;
        o_data = i_op1 >> i_op2[4:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc2_port_responder.sv
// calc2 single-port responder: two-cycle request capture, ALU, fixed-latency response line.
// Optional duplicate-tag rejection via CALC2_DUP_TAG_CHECK_EN. DATA_W must equal CALC2_DATA_W.
module calc2_port_responder
  import calc2_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DATA_W  = CALC2_DATA_W
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  input  logic [1:0]        req_tag_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_tag
);

  typedef enum logic {S_IDLE, S_OP2} state_t;

  state_t            r_state;
  logic [3:0]        r_cmd;
  logic [1:0]        r_tag;
  logic [DATA_W-1:0] r_op1;
  logic              w_issue;
  logic              w_dup;
  logic [1:0]        w_alu_resp;
  logic [DATA_W-1:0] w_alu_data;
  rsp_t              w_in;
  rsp_t              r_pipe [1:LATENCY];

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cmd   <= CMD_NOP;
      r_tag   <= '0;
      r_op1   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_cmd_in != CMD_NOP) begin
          r_cmd   <= req_cmd_in;
          r_tag   <= req_tag_in;
          r_op1   <= req_data_in;
          r_state <= S_OP2;
        end
        S_OP2:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_issue = (r_state == S_OP2);

  // Operand2 goes straight from the port into the ALU; it is captured by the delay line.
  calc2_alu #(.DATA_W(DATA_W)) u_alu (
    .i_cmd  (r_cmd),
    .i_op1  (r_op1),
    .i_op2  (req_data_in),
    .o_resp (w_alu_resp),
    .o_data (w_alu_data)
  );

`ifdef CALC2_DUP_TAG_CHECK_EN
  logic [3:0]         r_busy;
  logic [3:0]         w_clr;
  logic [3:0]         w_set;
  logic [LATENCY:1]   r_own;

  // r_own marks slots that set a busy bit, so a rejected duplicate never clears a live tag.
  always_comb begin
    w_clr = '0;
    if (r_own[LATENCY]) w_clr[r_pipe[LATENCY].tag] = 1'b1;
    w_dup = r_busy[r_tag] & ~w_clr[r_tag];
    w_set = '0;
    if (w_issue && !w_dup) w_set[r_tag] = 1'b1;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      r_own  <= '0;
    end else begin
      r_busy   <= (r_busy & ~w_clr) | w_set;
      r_own[1] <= |w_set;
      for (int k = 2; k <= LATENCY; k++) r_own[k] <= r_own[k-1];
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  always_comb begin
    w_in      = '0;
    w_in.tag  = r_tag;
    w_in.resp = w_dup ? RESP_ERR : w_alu_resp;
    w_in.data = w_dup ? '0 : w_alu_data;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= LATENCY; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[1] <= w_issue ? w_in : '0;
      for (int k = 2; k <= LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign out_resp = r_pipe[LATENCY].resp;
  assign out_data = r_pipe[LATENCY].data;
  assign out_tag  = r_pipe[LATENCY].tag;

endmodule

// File: tb/tb_calc2_port_responder.sv
// Bench for calc2_port_responder: vector table, hand sequences and random traffic vs a cycle-indexed model.
module tb_calc2_port_responder;

  localparam int L = 3;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_cmd_in = '0;
  logic [31:0] req_data_in = '0;
  logic [1:0]  req_tag_in = '0;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;

  calc2_port_responder #(.LATENCY(L), .DATA_W(32)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .req_tag_in  (req_tag_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_tag     (out_tag)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } exp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  exp_t exp_m [int];     // expected output keyed by response cycle
  int   busy_until [4];  // cycle in which the last accepted request of each tag responds
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge c_clk) cyc <= cyc + 1;

  function automatic exp_t ref_calc(input logic [3:0] cmd, input logic [1:0] tag,
                                    input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint s;
    r.tag = tag; r.resp = 2'd2; r.data = 32'd0;
    case (cmd)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s <= 64'hFFFF_FFFF) begin r.resp = 2'd1; r.data = s[31:0]; end
      end
      4'd2: if (b <= a) begin r.resp = 2'd1; r.data = a - b; end
      4'd5: begin r.resp = 2'd1; r.data = a << b[4:0]; end
      4'd6: begin r.resp = 2'd1; r.data = a >> b[4:0]; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_issue(input logic [3:0] cmd, input logic [1:0] tag,
                             input logic [31:0] a, input logic [31:0] b, input int c2);
    exp_t r;
    r = ref_calc(cmd, tag, a, b);
`ifdef CALC2_DUP_TAG_CHECK_EN
    if (busy_until[tag] > c2) begin
      r.resp = 2'd2; r.data = 32'd0;
    end else begin
      busy_until[tag] = c2 + L;
    end
`endif
    exp_m[c2 + L] = r;
  endtask

  task automatic step();
    @(posedge c_clk); #1;
  endtask

  // Drives a full request; returns the operand2 cycle index. Junk on cmd/tag during OP2 must be ignored.
  task automatic issue(input logic [3:0] cmd, input logic [1:0] tag,
                       input logic [31:0] a, input logic [31:0] b, output int c2);
    req_cmd_in = cmd; req_tag_in = tag; req_data_in = a;
    step();
    req_cmd_in = 4'($urandom); req_tag_in = 2'($urandom); req_data_in = b;
    c2 = cyc;
    model_issue(cmd, tag, a, b, c2);
    step();
    req_cmd_in = 4'd0; req_tag_in = 2'($urandom); req_data_in = $urandom;
  endtask

  task automatic check(input string name, input logic [1:0] resp, input logic [31:0] data,
                       input logic [1:0] tag);
    n_tests++;
    if (out_resp !== resp || out_data !== data || out_tag !== tag) begin
      n_fail++;
      $display("FAIL %s: got resp=%0d data=%h tag=%0d, want resp=%0d data=%h tag=%0d",
               name, out_resp, out_data, out_tag, resp, data, tag);
    end
  endtask

  always @(negedge c_clk) begin
    exp_t e;
    e.resp = 2'd0; e.data = 32'd0; e.tag = 2'd0;
    if (!reset && exp_m.exists(cyc)) e = exp_m[cyc];
    check($sformatf("mon cyc%0d", cyc), e.resp, e.data, e.tag);
  end

  vec_t vt [10];

  initial begin
    int c2, ca;
    logic [3:0] cmds [10];
    for (int t = 0; t < 4; t++) busy_until[t] = -1;

    vt[0] = '{4'd1, 2'd1, 32'd5,          32'd7,          2'd1, 32'd12};
    vt[1] = '{4'd1, 2'd2, 32'hFFFF_FFFF,  32'd1,          2'd2, 32'd0};
    vt[2] = '{4'd2, 2'd3, 32'd3,          32'd4,          2'd2, 32'd0};
    vt[3] = '{4'd5, 2'd0, 32'h0000_0001,  32'h0000_0024,  2'd1, 32'h0000_0010};
    vt[4] = '{4'd6, 2'd1, 32'h8000_0000,  32'd31,         2'd1, 32'h0000_0001};
    vt[5] = '{4'd2, 2'd1, 32'd9,          32'd4,          2'd1, 32'd5};
    vt[6] = '{4'd3, 2'd2, 32'd1,          32'd1,          2'd2, 32'd0};
    vt[7] = '{4'd2, 2'd3, 32'd4,          32'd4,          2'd1, 32'd0};
    vt[8] = '{4'd1, 2'd0, 32'hFFFF_FFFE,  32'd1,          2'd1, 32'hFFFF_FFFF};
    vt[9] = '{4'd15,2'd3, 32'd2,          32'd2,          2'd2, 32'd0};

    repeat (3) @(posedge c_clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(vt[i].cmd, vt[i].tag, vt[i].a, vt[i].b, c2);
      repeat (L - 1) @(posedge c_clk);
      @(negedge c_clk);
      check($sformatf("vec%0d", i), vt[i].resp, vt[i].data, vt[i].tag);
      step();
    end

    // Back-to-back: add, sub 9-4, invalid cmd 3, checked by the monitor.
    issue(4'd1, 2'd0, 32'd100, 32'd23, ca);
    issue(4'd2, 2'd1, 32'd9, 32'd4, c2);
    issue(4'd3, 2'd2, 32'd8, 32'd8, c2);
    repeat (L + 2) step();

    // Duplicate tag: second add reuses tag 1 while the first is still in flight.
    issue(4'd1, 2'd1, 32'd1, 32'd2, ca);
    issue(4'd1, 2'd1, 32'd3, 32'd4, c2);
    @(negedge c_clk);
    check("dup_first", 2'd1, 32'd3, 2'd1);
    @(posedge c_clk); @(posedge c_clk); @(negedge c_clk);
`ifdef CALC2_DUP_TAG_CHECK_EN
    check("dup_second", 2'd2, 32'd0, 2'd1);
`else
    check("dup_second", 2'd1, 32'd7, 2'd1);
`endif
    repeat (2) step();

    // Reset during the OP2 cycle of an add: the request must vanish.
    req_cmd_in = 4'd1; req_tag_in = 2'd3; req_data_in = 32'd5;
    step();
    req_cmd_in = 4'd0; req_data_in = 32'd6;
    reset = 1'b1;
    exp_m.delete();
    for (int t = 0; t < 4; t++) busy_until[t] = -1;
    @(negedge c_clk);
    check("rst_outputs", 2'd0, 32'd0, 2'd0);
    step(); step();
    reset = 1'b0;
    issue(4'd1, 2'd2, 32'd1, 32'd1, c2);
    repeat (L - 1) @(posedge c_clk);
    @(negedge c_clk);
    check("post_rst_add", 2'd1, 32'd2, 2'd2);
    step();

    // Random traffic against the model; small tag space makes duplicates frequent.
    cmds = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd15};
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
      issue(cmds[$urandom_range(0, 9)], 2'($urandom), a, b, c2);
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (L + 2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc2_port_responder.md
Name: calc2_port_responder

Overview:
- Single-port, synthesizable responder for the calc2 request/response protocol.
- Accepts a two-cycle request: cycle 1 carries cmd, tag and operand1; cycle 2 carries operand2.
- Executes add, subtract, shift-left or shift-right and returns resp/data/tag after a fixed, parameterized latency.
- Used as a standalone golden responder and as the building block for a multi-port calculator. It is the far end of the request driver in the calc2 bench.

Parameters:
- LATENCY, 3, cycles from the operand2 cycle to the response cycle; legal range 1..8.
- DATA_W, 32, operand and result width.

Ports:
- c_clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_cmd_in  input  4  command; 0 = no-op, 1 = add, 2 = sub, 5 = shl, 6 = shr.
- req_data_in  input  DATA_W  operand1 in the cmd cycle, operand2 in the following cycle.
- req_tag_in  input  2  request tag, sampled in the cmd cycle only.
- out_resp  output  2  0 = none, 1 = success, 2 = overflow/underflow/invalid/dup-tag error, 3 = never driven.
- out_data  output  DATA_W  result; 0 whenever out_resp != 1.
- out_tag  output  2  tag of the response; 0 when out_resp = 0.

Behaviour:
- Reset: asynchronous. While reset is high, out_resp, out_data and out_tag are 0, the FSM is in IDLE, the delay line is empty and the outstanding-tag bitmap is clear.
- Reset asserted mid-operation drops every in-flight request; no response for it is ever produced.
- Input FSM has two states, IDLE and OP2:
  - IDLE, req_cmd_in = 0: stay in IDLE.
  - IDLE, req_cmd_in != 0: latch cmd, tag and op1 (req_data_in); go to OP2.
  - OP2: latch op2 (req_data_in), issue the operation into the delay line, return to IDLE. req_cmd_in and req_tag_in are ignored in OP2.
- Issue rate: at most one request per 2 cycles. Back-to-back commands (a cmd in the cycle right after OP2) are accepted.
- Arithmetic is performed by calc2_alu, combinationally, in the OP2 cycle:
  - add: 33-bit sum; carry-out = 1 gives resp 2, data 0.
  - sub: op2 > op1 (unsigned) gives resp 2, data 0; otherwise op1 - op2.
  - shl / shr: logical shift by op2[4:0]; upper bits of op2 are ignored; always resp 1.
  - Any other nonzero cmd (3, 4, 7..15) gives resp 2, data 0.
- Delay line: LATENCY-stage shift register of {valid, resp, data, tag}.
  - For op2 sampled at edge T, outputs are valid during the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles after the operand2 cycle.
  - The response is a one-cycle pulse; outputs return to 0 the next cycle unless another response follows.
  - No output collisions are possible; responses leave in issue order.
- Outputs are registered (last delay-line stage); no combinational path from the inputs.

Optional Feature:
- Macro: CALC2_DUP_TAG_CHECK_EN.
- Enabled:
  - A 4-bit outstanding bitmap is set at the OP2 cycle and cleared in the response cycle.
  - A request whose tag is already outstanding still consumes its two cycles and is not executed.
  - It produces resp 2, data 0 with its tag at normal latency, and does not re-set the bitmap.
  - If a response for tag X and a new issue of tag X occur on the same edge, the clear wins, so the new request is legal.
- Disabled: no bitmap; duplicate tags execute normally.

Decomposition:
- calc2_pkg holds:
  - cmd constants: CMD_NOP = 0, CMD_ADD = 1, CMD_SUB = 2, CMD_SHL = 5, CMD_SHR = 6.
  - resp constants: RESP_NONE = 0, RESP_OK = 1, RESP_ERR = 2.
  - a typedef for the response struct {resp, data, tag}.
- One sub-module, calc2_alu: purely combinational; inputs cmd, op1, op2; outputs resp and data.

Test Plan:
1. Add, LATENCY = 3, out of reset:
   - Stimulus: cycle 0 cmd 1, tag 1, data 5; cycle 1 data 7.
   - Response: cycle 4 resp 1, data 12, tag 1; cycle 5 resp 0.
2. Add overflow:
   - Stimulus: op1 FFFF_FFFF + op2 1, tag 2.
   - Response: resp 2, data 0, tag 2; then sub 3 - 4, tag 3 gives resp 2, data 0.
3. Shifts:
   - Stimulus: shl op1 0000_0001 by op2 0000_0024, tag 0; then shr op1 8000_0000 by 31, tag 1.
   - Response: shl gives data 0000_0010; shr gives data 0000_0001; both resp 1.
4. Back-to-back requests:
   - Stimulus: add (tag 0), sub 9 - 4 (tag 1) and invalid cmd 3 (tag 2), issued every 2 cycles.
   - Response: three responses in order, 2 cycles apart: (1, sum, 0), (1, 5, 1), (2, 0, 2).
5. Reset mid-operation:
   - Stimulus: assert reset in the OP2 cycle of an add, then hold reset for 2 cycles.
   - Response: no response ever appears for it; a subsequent add 1 + 1 returns data 2 at normal latency.
6. Duplicate tag (CALC2_DUP_TAG_CHECK_EN defined):
   - Stimulus: two adds, both tag 1, the second issued while the first is outstanding.
   - Response: first gives resp 1; second gives resp 2, data 0, tag 1.
   - Without the macro, both give resp 1.
